// File: rtl/player_attack_multi.sv
// Attack timing engine: per-type length and hitbox window, aged single-slot request buffer,
// post-attack cooldown, lowest-index priority and immediate hit abort. Advances on SCEN ticks.
module player_attack_multi #(
    parameter int                         NUM_ATK         = 2,
    parameter int                         FRAME_W         = 6,
    parameter logic [NUM_ATK*FRAME_W-1:0] ATK_TOTAL       = {6'd26, 6'd18},
    parameter logic [NUM_ATK*FRAME_W-1:0] ATK_ACT_START   = {6'd8, 6'd4},
    parameter logic [NUM_ATK*FRAME_W-1:0] ATK_ACT_END     = {6'd16, 6'd10},
    parameter int                         COOLDOWN_FRAMES = 2,
    parameter int                         BUF_FRAMES      = 8,
    localparam int                        TW              = $clog2(NUM_ATK + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               SCEN,
    input  logic               attack_enable,
    input  logic [NUM_ATK-1:0] attack_req,
    input  logic               abort,
    output logic               attack_busy,
    output logic               attack_active,
    output logic [TW-1:0]      attack_type,
    output logic [FRAME_W-1:0] attack_frame,
    output logic               attack_start,
    output logic               attack_done
);

    localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam int AGE_W = (BUF_FRAMES > 0) ? $clog2(BUF_FRAMES + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ATTACK   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    for (genvar k = 0; k < NUM_ATK; k++) begin : g_param_chk
        if ((ATK_TOTAL[k*FRAME_W +: FRAME_W] == '0) ||
            (ATK_ACT_START[k*FRAME_W +: FRAME_W] > ATK_ACT_END[k*FRAME_W +: FRAME_W]) ||
            (ATK_ACT_END[k*FRAME_W +: FRAME_W] >= ATK_TOTAL[k*FRAME_W +: FRAME_W])) begin : g_bad
            $error("player_attack_multi: inconsistent timing fields for attack %0d", k);
        end
    end

    if ((NUM_ATK < 1) || (NUM_ATK > 7)) begin : g_num_chk
        $error("player_attack_multi: NUM_ATK must be 1..7");
    end

    function automatic logic [TW-1:0] first_set(input logic [NUM_ATK-1:0] v);
        first_set = '0;
        for (int k = NUM_ATK - 1; k >= 0; k--) begin
            if (v[k]) first_set = TW'(k + 1);
        end
    endfunction

    // Selects the timing field of the running type; type 0 yields 0.
    function automatic logic [FRAME_W-1:0] field_of(input logic [NUM_ATK*FRAME_W-1:0] packed_v,
                                                    input logic [TW-1:0] t);
        field_of = '0;
        for (int k = 0; k < NUM_ATK; k++) begin
            if (t == TW'(k + 1)) field_of = packed_v[k*FRAME_W +: FRAME_W];
        end
    endfunction

    state_t               state_q, state_d;
    logic [NUM_ATK-1:0]   pend_q, pend_d;
    logic [AGE_W-1:0]     age_q, age_d, age_inc_s;
    logic [TW-1:0]        type_q, type_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [CD_W-1:0]      cd_q, cd_d;
    logic                 start_q, start_d;
    logic                 done_q, done_d;

    // Next-state: abort dominates, then enable gating, then buffer capture/aging and the tick FSM.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        age_d     = age_q;
        age_inc_s = age_q;
        type_d    = type_q;
        frame_d   = frame_q;
        cd_d      = cd_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            pend_d  = '0;
            age_d   = '0;
            type_d  = '0;
            frame_d = '0;
            cd_d    = '0;
        end else if (!attack_enable) begin
            pend_d = '0;
            age_d  = '0;
        end else begin
            if ((|attack_req) && ((state_q == ST_IDLE) || (BUF_FRAMES != 0))) begin
                pend_d = pend_q | attack_req;
                age_d  = '0;
            end else if (SCEN && (state_q != ST_IDLE) && (|pend_q)) begin
                age_inc_s = (age_q == AGE_MAX) ? age_q : age_q + AGE_W'(1);
                age_d     = age_inc_s;
                if (age_inc_s == AGE_W'(BUF_FRAMES)) begin
                    pend_d = '0;
                end else begin
                    pend_d = pend_q;
                end
            end else begin
                pend_d = pend_q;
            end

            if (SCEN) begin
                case (state_q)
                    ST_IDLE: begin
                        if (|pend_q) begin
                            state_d = ST_ATTACK;
                            type_d  = first_set(pend_q);
                            frame_d = '0;
                            start_d = 1'b1;
                            pend_d  = '0;
                            age_d   = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_ATTACK: begin
                        if (frame_q == field_of(ATK_TOTAL, type_q) - FRAME_W'(1)) begin
                            done_d  = 1'b1;
                            type_d  = '0;
                            frame_d = '0;
                            cd_d    = CD_W'(COOLDOWN_FRAMES);
                            state_d = (COOLDOWN_FRAMES == 0) ? ST_IDLE : ST_COOLDOWN;
                        end else begin
                            frame_d = frame_q + FRAME_W'(1);
                        end
                    end
                    ST_COOLDOWN: begin
                        if (cd_q <= CD_W'(1)) begin
                            cd_d    = '0;
                            state_d = ST_IDLE;
                        end else begin
                            cd_d = cd_q - CD_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end else begin
                state_d = state_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            age_q   <= '0;
            type_q  <= '0;
            frame_q <= '0;
            cd_q    <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            age_q   <= age_d;
            type_q  <= type_d;
            frame_q <= frame_d;
            cd_q    <= cd_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign attack_busy   = (state_q == ST_ATTACK);
    assign attack_active = attack_busy &&
                           (frame_q >= field_of(ATK_ACT_START, type_q)) &&
                           (frame_q <= field_of(ATK_ACT_END, type_q));
    assign attack_type   = type_q;
    assign attack_frame  = frame_q;
    assign attack_start  = start_q;
    assign attack_done   = done_q;

endmodule

// File: tb/tb_player_attack_multi.sv
// Scoreboard bench: two engines (buffer 8 and buffer 4 ticks) share stimulus; a per-cycle
// reference model queues expected outputs which are popped and compared after each edge.
module tb_player_attack_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       SCEN = 1'b0;
    logic       attack_enable = 1'b0;
    logic [1:0] attack_req = 2'b00;
    logic       abort = 1'b0;

    logic       busy8, act8, start8, done8;
    logic [1:0] type8;
    logic [5:0] frame8;
    logic       busy4, act4, start4, done4;
    logic [1:0] type4;
    logic [5:0] frame4;

    always #5 clk = ~clk;

    player_attack_multi #(.BUF_FRAMES(8)) dut8 (
        .clk(clk), .reset(reset), .SCEN(SCEN), .attack_enable(attack_enable),
        .attack_req(attack_req), .abort(abort),
        .attack_busy(busy8), .attack_active(act8), .attack_type(type8),
        .attack_frame(frame8), .attack_start(start8), .attack_done(done8)
    );

    player_attack_multi #(.BUF_FRAMES(4)) dut4 (
        .clk(clk), .reset(reset), .SCEN(SCEN), .attack_enable(attack_enable),
        .attack_req(attack_req), .abort(abort),
        .attack_busy(busy4), .attack_active(act4), .attack_type(type4),
        .attack_frame(frame4), .attack_start(start4), .attack_done(done4)
    );

    typedef struct {
        int busy;
        int act;
        int typ;
        int frm;
        int start;
        int done;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    int ms_st[2], ms_typ[2], ms_frm[2], ms_cd[2], ms_pend[2], ms_age[2], ms_start[2], ms_done[2];
    int buf_v[2] = '{8, 4};

    logic [31:0] act_mask8;
    int n_start8 = 0, n_start4 = 0, n_done8 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
        n_chk++;
        if (obs !== 32'(exp_v)) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int total_of(input int t);
        return (t == 1) ? 18 : 26;
    endfunction
    function automatic int act_lo(input int t);
        return (t == 1) ? 4 : 8;
    endfunction
    function automatic int act_hi(input int t);
        return (t == 1) ? 10 : 16;
    endfunction

    task automatic model_step(input int m);
        exp_t e;
        int np, na;
        if (reset || abort) begin
            ms_st[m] = 0; ms_typ[m] = 0; ms_frm[m] = 0; ms_cd[m] = 0;
            ms_pend[m] = 0; ms_age[m] = 0; ms_start[m] = 0; ms_done[m] = 0;
        end else begin
            ms_start[m] = 0;
            ms_done[m]  = 0;
            if (!attack_enable) begin
                ms_pend[m] = 0;
                ms_age[m]  = 0;
            end else begin
                np = ms_pend[m];
                na = ms_age[m];
                if (attack_req != 2'b00 && (ms_st[m] == 0 || buf_v[m] > 0)) begin
                    np = np | int'(attack_req);
                    na = 0;
                end else if (SCEN && ms_st[m] != 0 && ms_pend[m] != 0) begin
                    na = ms_age[m] + 1;
                    if (na == buf_v[m]) np = 0;
                end
                if (SCEN) begin
                    case (ms_st[m])
                        0: if (ms_pend[m] != 0) begin
                            ms_typ[m] = ((ms_pend[m] & 1) != 0) ? 1 : 2;
                            ms_frm[m] = 0; ms_st[m] = 1; ms_start[m] = 1;
                            np = 0; na = 0;
                        end
                        1: if (ms_frm[m] == total_of(ms_typ[m]) - 1) begin
                            ms_done[m] = 1; ms_typ[m] = 0; ms_frm[m] = 0;
                            ms_cd[m] = 2; ms_st[m] = 2;
                        end else begin
                            ms_frm[m]++;
                        end
                        2: begin
                            ms_cd[m]--;
                            if (ms_cd[m] == 0) ms_st[m] = 0;
                        end
                        default: ;
                    endcase
                end
                ms_pend[m] = np;
                ms_age[m]  = na;
            end
        end
        e.busy  = (ms_st[m] == 1) ? 1 : 0;
        e.act   = (ms_st[m] == 1 && ms_frm[m] >= act_lo(ms_typ[m]) &&
                   ms_frm[m] <= act_hi(ms_typ[m])) ? 1 : 0;
        e.typ   = ms_typ[m];
        e.frm   = ms_frm[m];
        e.start = ms_start[m];
        e.done  = ms_done[m];
        exp_q.push_back(e);
    endtask

    task automatic compare_outputs();
        exp_t e;
        e = exp_q.pop_front();
        chk("busy8", busy8, e.busy);   chk("active8", act8, e.act);
        chk("type8", type8, e.typ);    chk("frame8", frame8, e.frm);
        chk("start8", start8, e.start); chk("done8", done8, e.done);
        e = exp_q.pop_front();
        chk("busy4", busy4, e.busy);   chk("active4", act4, e.act);
        chk("type4", type4, e.typ);    chk("frame4", frame4, e.frm);
        chk("start4", start4, e.start); chk("done4", done4, e.done);
    endtask

    task automatic drive(input logic s, input logic e, input logic [1:0] r,
                         input logic a, input logic rs);
        @(negedge clk);
        SCEN = s; attack_enable = e; attack_req = r; abort = a; reset = rs;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_outputs();
        if (act8) act_mask8 = act_mask8 | (32'd1 << frame8);
        if (start8) n_start8++;
        if (start4) n_start4++;
        if (done8) n_done8++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
            drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int s8, s4, d8, start_tick;
        act_mask8 = '0;

        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);

        // Single attack 0: window, done and cooldown
        d8 = n_done8;
        drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        ticks(22);
        chk("act_window", act_mask8, 32'h7F0);
        chk("done_once", 32'(n_done8 - d8), 1);

        // Both requests together: attack 0 only
        s8 = n_start8;
        drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        ticks(25);
        chk("dual_req_starts", 32'(n_start8 - s8), 1);

        // Buffered request aged out in the 4-tick engine only
        drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        ticks(16);
        chk("at_frame15", frame8, 15);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
        s4 = n_start4;
        start_tick = 0;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
            drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
            if (start8 && start_tick == 0) start_tick = i;
        end
        chk("buf8_start_tick", start_tick, 6);
        chk("buf4_no_start", 32'(n_start4 - s4), 0);

        // Abort during the hitbox window of attack 1
        ticks(7);
        chk("pre_abort_frame", frame8, 9);
        chk("pre_abort_active", act8, 1);
        d8 = n_done8;
        drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
        chk("abort_busy", busy8, 0);
        ticks(3);
        chk("abort_no_done", 32'(n_done8 - d8), 0);

        // Abort coincident with a tick suppresses the start
        drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        s8 = n_start8;
        drive(1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
        ticks(2);
        chk("abort_tick_no_start", 32'(n_start8 - s8), 0);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
        ticks(1);
        chk("after_abort_type", type8, 2);
        ticks(28);

        // Enable low freezes the frame and ignores requests
        drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        ticks(4);
        drive(1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        end
        chk("en_hold", frame8, 3);
        ticks(1);
        chk("en_resume", frame8, 4);
        ticks(20);
        chk("en_req_ignored", busy8, 0);

        // Reset mid-attack with a request buffered
        drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        ticks(8);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
        chk("pre_reset_frame", frame8, 7);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
        chk("reset_type", type8, 0);
        s8 = n_start8;
        ticks(3);
        chk("reset_pending_cleared", 32'(n_start8 - s8), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
